dual_rail_rx: RTL and testbench

DUAL_RAIL_RX -- requirements
Module: dual_rail_rx

---
 rtl/dual_rail_rx.sv | 146 ++++++++++++++
 tb/tb_dual_rail_rx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/dual_rail_rx.sv
// Receiver for a complementary (dual-rail) bit pair. Samples both rails,
// checks that they disagree, locks after a short run of valid samples and
// raises a sticky alarm when too many invalid samples arrive back to back.
module dual_rail_rx #(
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_p,
  input  logic             in_n,
  input  logic             clr_err,
  output logic             data_out,
  output logic             data_vld,
  output logic             fault,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    SYNC   = 2'b00,
    LOCK   = 2'b01,
    ALARM  = 2'b10,
    UNUSED = 2'b11
  } state_t;

  localparam logic [3:0] THRESH = 4'(ERR_THRESH);

  state_t           st_q, st_d;
  logic             s_p, s_n;
  // Low for the first edge after reset so the reset value of the sample
  // flops is never evaluated as a real sample.
  logic             armed;
  logic [1:0]       valid_run, valid_run_d;
  logic [3:0]       bad_run, bad_run_d;
  logic             data_out_d, data_vld_d, fault_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic             sample_ok;
  logic [3:0]       bad_next;

  assign sample_ok = s_p ^ s_n;
  assign bad_next  = bad_run + 4'd1;
  assign state     = st_q;

  // Input sample flops; reset to the valid pair 0/1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_p   <= 1'b0;
      s_n   <= 1'b1;
      armed <= 1'b0;
    end else begin
      s_p   <= in_p;
      s_n   <= in_n;
      armed <= 1'b1;
    end
  end

  // Next-state, run counters, outputs and error counter from the sampled pair.
  always_comb begin
    st_d        = st_q;
    valid_run_d = valid_run;
    bad_run_d   = bad_run;
    data_out_d  = data_out;
    data_vld_d  = 1'b0;
    fault_d     = fault;
    err_cnt_d   = err_cnt;

    if (armed && !sample_ok && (err_cnt != '1)) begin
      err_cnt_d = err_cnt + CNT_W'(1);
    end

    unique case (st_q)
      SYNC: begin
        fault_d = 1'b0;
        if (armed) begin
          if (sample_ok) begin
            if (valid_run == 2'd1) begin
              st_d        = LOCK;
              valid_run_d = '0;
              bad_run_d   = '0;
            end else begin
              valid_run_d = valid_run + 2'd1;
            end
          end else begin
            valid_run_d = '0;
          end
        end
      end
      LOCK: begin
        if (sample_ok) begin
          data_out_d = s_p;
          data_vld_d = 1'b1;
          bad_run_d  = '0;
        end else begin
          bad_run_d = bad_next;
          if (bad_next == THRESH) begin
            st_d    = ALARM;
            fault_d = 1'b1;
          end
        end
      end
      ALARM: begin
        fault_d = 1'b1;
      end
      default: begin
        st_d        = SYNC;
        valid_run_d = '0;
        bad_run_d   = '0;
        fault_d     = 1'b0;
      end
    endcase

    // Clear wins over a coincident invalid-sample increment.
    if (clr_err) begin
      err_cnt_d = '0;
      if (st_q == ALARM) begin
        st_d        = SYNC;
        fault_d     = 1'b0;
        valid_run_d = '0;
        bad_run_d   = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q      <= SYNC;
      valid_run <= '0;
      bad_run   <= '0;
      data_out  <= 1'b0;
      data_vld  <= 1'b0;
      fault     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      st_q      <= st_d;
      valid_run <= valid_run_d;
      bad_run   <= bad_run_d;
      data_out  <= data_out_d;
      data_vld  <= data_vld_d;
      fault     <= fault_d;
      err_cnt   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_dual_rail_rx.sv
// Table-driven bench for dual_rail_rx with a second instance (CNT_W=4)
// used for the err_cnt saturation sequence.
module tb_dual_rail_rx;

  typedef struct {
    logic       r, p, n, c;
    logic [1:0] st;
    logic       dout, vld, flt;
    logic [7:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, in_p, in_n, clr_err;
  logic       data_out, data_vld, fault;
  logic [7:0] err_cnt;
  logic [1:0] state;

  logic       rst2, in_p2, in_n2, clr2;
  logic       data_out2, data_vld2, fault2;
  logic [3:0] err_cnt2;
  logic [1:0] state2;

  int total = 0;
  int bad   = 0;
  int row   = 0;

  vec_t tbl[33];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  dual_rail_rx #(.ERR_THRESH(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_p(in_p), .in_n(in_n), .clr_err(clr_err),
    .data_out(data_out), .data_vld(data_vld), .fault(fault),
    .err_cnt(err_cnt), .state(state)
  );

  dual_rail_rx #(.ERR_THRESH(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst2), .in_p(in_p2), .in_n(in_n2), .clr_err(clr2),
    .data_out(data_out2), .data_vld(data_vld2), .fault(fault2),
    .err_cnt(err_cnt2), .state(state2)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%0d expected=%0d", name, row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, p, n, c, input logic [1:0] st,
                              input logic dout, vld, flt, input logic [7:0] cnt);
    vec_t v;
    v.r = r; v.p = p; v.n = n; v.c = c;
    v.st = st; v.dout = dout; v.vld = vld; v.flt = flt; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    vec_t e;
    int   exp_cnt;

    //            r  p  n  c  st dout vld flt cnt
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);  // reset sample not evaluated
    tbl[3]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0);  // 1st valid
    tbl[4]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 0);  // 2nd valid -> LOCK
    tbl[5]  = mk(1, 0, 1, 0, 1, 1, 1, 0, 0);  // data 1
    tbl[6]  = mk(1, 1, 1, 0, 1, 0, 1, 0, 0);  // data 0
    tbl[7]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 1);  // glitch 11
    tbl[8]  = mk(1, 0, 0, 1, 1, 1, 1, 0, 0);  // clr in LOCK
    tbl[9]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 1);
    tbl[10] = mk(1, 0, 0, 0, 1, 1, 0, 0, 2);
    tbl[11] = mk(1, 1, 0, 0, 2, 1, 0, 1, 3);  // 3rd bad -> ALARM
    tbl[12] = mk(1, 1, 1, 0, 2, 1, 0, 1, 3);  // valid in ALARM
    tbl[13] = mk(1, 1, 1, 1, 0, 1, 0, 0, 0);  // clr + invalid
    tbl[14] = mk(1, 1, 0, 0, 0, 1, 0, 0, 1);
    tbl[15] = mk(1, 0, 1, 0, 0, 1, 0, 0, 1);
    tbl[16] = mk(1, 1, 0, 0, 1, 1, 0, 0, 1);
    tbl[17] = mk(1, 0, 0, 0, 1, 1, 1, 0, 1);
    tbl[18] = mk(1, 0, 1, 0, 1, 1, 0, 0, 2);
    tbl[19] = mk(1, 0, 0, 0, 1, 0, 1, 0, 2);
    tbl[20] = mk(1, 0, 1, 0, 1, 0, 0, 0, 3);
    tbl[21] = mk(1, 1, 1, 0, 1, 0, 1, 0, 3);
    tbl[22] = mk(1, 1, 0, 0, 1, 0, 0, 0, 4);
    tbl[23] = mk(1, 0, 0, 0, 1, 1, 1, 0, 4);
    tbl[24] = mk(1, 1, 1, 0, 1, 1, 0, 0, 5);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset mid-LOCK
    tbl[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[27] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[28] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[29] = mk(1, 0, 1, 0, 0, 0, 0, 0, 2);  // invalid restarts run
    tbl[30] = mk(1, 1, 0, 0, 0, 0, 0, 0, 2);
    tbl[31] = mk(1, 1, 0, 0, 1, 0, 0, 0, 2);
    tbl[32] = mk(1, 0, 1, 0, 1, 1, 1, 0, 2);

    rst = 1'b0; in_p = 1'b0; in_n = 1'b0; clr_err = 1'b0;
    rst2 = 1'b0; in_p2 = 1'b0; in_n2 = 1'b0; clr2 = 1'b0;

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      rst = tbl[i].r; in_p = tbl[i].p; in_n = tbl[i].n; clr_err = tbl[i].c;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      row = i;
      e = exp_q.pop_front();
      chk("state",    int'(state),    int'(e.st));
      chk("data_out", int'(data_out), int'(e.dout));
      chk("data_vld", int'(data_vld), int'(e.vld));
      chk("fault",    int'(fault),    int'(e.flt));
      chk("err_cnt",  int'(err_cnt),  int'(e.cnt));
    end

    // Saturation on the 4-bit counter: continuous 00 samples.
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      rst2 = (k >= 2); in_p2 = 1'b0; in_n2 = 1'b0; clr2 = 1'b0;
      exp_cnt = (k < 3) ? 0 : ((k - 2 > 15) ? 15 : k - 2);
      e = mk(rst2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'(exp_cnt));
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      row = 100 + k;
      e = exp_q.pop_front();
      chk("sat_err_cnt", int'(err_cnt2), int'(e.cnt));
      chk("sat_state",   int'(state2),   int'(e.st));
      chk("sat_vld",     int'(data_vld2), int'(e.vld));
      chk("sat_dout",    int'(data_out2), int'(e.dout));
      chk("sat_fault",   int'(fault2),    int'(e.flt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
